// File: rtl/key_vaild_gen.sv
// key_vaild_gen: push-button front end for the LED flasher.
// Synchronises a raw bouncy key, debounces it with a four-state FSM and
// toggles the flash enable (vaild) once per accepted press. Also provides
// one-cycle press/release strobes, the debounced level and a wrapping
// count of accepted presses.
//
// Handshake: none. key_in is a free-running asynchronous level; every output
// is a registered level or a one-cycle strobe, valid on every clock.
//
// state_dbg exposes the FSM state: 0 IDLE, 1 PRESS_WAIT, 2 HELD, 3 RELEASE_WAIT.
module key_vaild_gen #(
  parameter int                CNT_W        = 24,
  parameter logic [CNT_W-1:0]  DEBOUNCE_CNT = CNT_W'(999_999),
  parameter int                KEY_ACT_LOW  = 1
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       vaild,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       key_level,
  output logic [7:0] press_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Pin level that means "not pressed"; sync flops reset to it so no
  // phantom press is seen after reset.
  localparam logic REL_LVL = (KEY_ACT_LOW != 0) ? 1'b1 : 1'b0;

  logic             sync1_q;
  logic             sync2_q;
  logic             act;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             vaild_q;
  logic             press_pulse_q;
  logic             release_pulse_q;
  logic             key_level_q;
  logic [7:0]       press_cnt_q;

  // Two-flop synchroniser for the asynchronous key pin.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // Polarity-normalised key: 1 = pressed.
  assign act = sync2_q ^ REL_LVL;

  // Debounce FSM with registered outputs; pulses default low each edge.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      vaild_q         <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      key_level_q     <= 1'b0;
      press_cnt_q     <= 8'd0;
    end else begin
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (act) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!act) begin
            // Bounce: level did not hold long enough.
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DEBOUNCE_CNT) begin
            state_q       <= HELD;
            press_pulse_q <= 1'b1;
            vaild_q       <= ~vaild_q;
            key_level_q   <= 1'b1;
            press_cnt_q   <= press_cnt_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          // Holding the key never repeats; only a release moves on.
          if (!act) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (act) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DEBOUNCE_CNT) begin
            state_q         <= IDLE;
            release_pulse_q <= 1'b1;
            key_level_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign vaild         = vaild_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign key_level     = key_level_q;
  assign press_cnt     = press_cnt_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_key_vaild_gen.sv
// Bench for key_vaild_gen with a short debounce window (DEBOUNCE_CNT=4,
// active-low key). A run-length reference model predicts every output on
// every cycle; a segment table and hand sequences cover the named scenarios.
module tb_key_vaild_gen;

  localparam int D = 4;

  logic       sys_clk;
  logic       rst;
  logic       key_in;
  logic       vaild;
  logic       press_pulse;
  logic       release_pulse;
  logic       key_level;
  logic [7:0] press_cnt;
  logic [1:0] state_dbg;

  int vectors;
  int miscompares;

  key_vaild_gen #(
    .CNT_W        (24),
    .DEBOUNCE_CNT (24'd4),
    .KEY_ACT_LOW  (1)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .key_in        (key_in),
    .vaild         (vaild),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .key_level     (key_level),
    .press_cnt     (press_cnt),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model ----------------
  // The debounced level flips once the pressed/released indication (key pin
  // seen two clocks late) has disagreed with it for D+2 consecutive clocks.
  logic [1:0] m_hist;     // [0] newest pin sample, [1] older
  logic       m_level;
  logic       m_vaild;
  logic       m_pp;
  logic       m_rp;
  logic [7:0] m_cnt;
  int         m_run;

  task automatic model_edge(input logic r, input logic k);
    logic pressed_now;
    if (r) begin
      m_hist  = 2'b11;
      m_level = 1'b0;
      m_vaild = 1'b0;
      m_pp    = 1'b0;
      m_rp    = 1'b0;
      m_cnt   = 8'd0;
      m_run   = 0;
    end else begin
      pressed_now = (m_hist[1] == 1'b0);
      m_hist = {m_hist[0], k};
      m_pp = 1'b0;
      m_rp = 1'b0;
      if (pressed_now != m_level) begin
        m_run = m_run + 1;
        if (m_run == D + 2) begin
          m_level = pressed_now;
          m_run   = 0;
          if (pressed_now) begin
            m_pp    = 1'b1;
            m_vaild = ~m_vaild;
            m_cnt   = m_cnt + 8'd1;
          end else begin
            m_rp = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  function automatic logic [1:0] model_state();
    if (m_run == 0) return m_level ? 2'd2 : 2'd0;
    return m_level ? 2'd3 : 2'd1;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_model(input string name);
    logic [12:0] got, exp;
    got = {vaild, press_pulse, release_pulse, key_level, press_cnt, state_dbg};
    exp = {m_vaild, m_pp, m_rp, m_level, m_cnt, model_state()};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got v/pp/rp/lvl/cnt/st=%b/%b/%b/%b/%0d/%0d want %b/%b/%b/%b/%0d/%0d",
               name, $time, vaild, press_pulse, release_pulse, key_level, press_cnt, state_dbg,
               m_vaild, m_pp, m_rp, m_level, m_cnt, model_state());
    end
  endtask

  task automatic check_val(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, actual, required);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic step(input logic r, input logic k, input string name);
    rst    = r;
    key_in = k;
    @(posedge sys_clk);
    #1;
    model_edge(r, k);
    check_model(name);
  endtask

  typedef struct {
    logic       rst;
    logic       key;
    int         len;
    logic       exp_vaild;
    logic       exp_level;
    logic [7:0] exp_cnt;
    int         pp_at;   // step index of the single press pulse, 0 = none
    int         rp_at;   // step index of the single release pulse, 0 = none
  } seg_t;

  seg_t tbl [10];

  initial begin
    int pp_n, pp_i, rp_n, rp_i;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    key_in      = 1'b1;
    m_hist = 2'b11; m_level = 0; m_vaild = 0; m_pp = 0; m_rp = 0; m_cnt = 0; m_run = 0;

    // reset, idle, bounce (3 low / 2 high / 3 low), clean press/release pairs
    tbl[0] = '{1'b1, 1'b1,  2, 1'b0, 1'b0, 8'd0, 0, 0};
    tbl[1] = '{1'b0, 1'b1,  3, 1'b0, 1'b0, 8'd0, 0, 0};
    tbl[2] = '{1'b0, 1'b0,  3, 1'b0, 1'b0, 8'd0, 0, 0};
    tbl[3] = '{1'b0, 1'b1,  2, 1'b0, 1'b0, 8'd0, 0, 0};
    tbl[4] = '{1'b0, 1'b0,  3, 1'b0, 1'b0, 8'd0, 0, 0};
    tbl[5] = '{1'b0, 1'b1, 10, 1'b0, 1'b0, 8'd0, 0, 0};
    tbl[6] = '{1'b0, 1'b0, 20, 1'b1, 1'b1, 8'd1, 8, 0};
    tbl[7] = '{1'b0, 1'b1, 20, 1'b1, 1'b0, 8'd1, 0, 8};
    tbl[8] = '{1'b0, 1'b0, 20, 1'b0, 1'b1, 8'd2, 8, 0};
    tbl[9] = '{1'b0, 1'b1, 20, 1'b0, 1'b0, 8'd2, 0, 8};

    for (int s = 0; s < 10; s++) begin
      pp_n = 0; pp_i = 0; rp_n = 0; rp_i = 0;
      for (int i = 1; i <= tbl[s].len; i++) begin
        step(tbl[s].rst, tbl[s].key, "table_step");
        if (press_pulse)   begin pp_n++; pp_i = i; end
        if (release_pulse) begin rp_n++; rp_i = i; end
      end
      check_val("seg_vaild",     int'(vaild),     int'(tbl[s].exp_vaild));
      check_val("seg_key_level", int'(key_level), int'(tbl[s].exp_level));
      check_val("seg_press_cnt", int'(press_cnt), int'(tbl[s].exp_cnt));
      check_val("seg_pp_count",  pp_n, (tbl[s].pp_at != 0) ? 1 : 0);
      check_val("seg_pp_step",   pp_i, tbl[s].pp_at);
      check_val("seg_rp_count",  rp_n, (tbl[s].rp_at != 0) ? 1 : 0);
      check_val("seg_rp_step",   rp_i, tbl[s].rp_at);
    end

    // Reset during PRESS_WAIT with cnt=2
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "midop_press");
    check_val("pw_state", int'(state_dbg), 1);
    step(1'b1, 1'b1, "midop_rst1");
    check_val("rst_pw_state", int'(state_dbg), 0);
    check_val("rst_pw_vaild", int'(vaild), 0);
    check_val("rst_pw_cnt",   int'(press_cnt), 0);
    check_val("rst_pw_pulse", int'(press_pulse | release_pulse), 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, "after_rst1");
      check_val("after_rst1_pulse", int'(press_pulse | release_pulse), 0);
    end

    // Reset during HELD
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, "midop_hold");
    check_val("held_state", int'(state_dbg), 2);
    check_val("held_vaild", int'(vaild), 1);
    step(1'b1, 1'b0, "midop_rst2");
    check_val("rst_held_state", int'(state_dbg), 0);
    check_val("rst_held_vaild", int'(vaild), 0);
    check_val("rst_held_cnt",   int'(press_cnt), 0);
    check_val("rst_held_level", int'(key_level), 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, "after_rst2");
      check_val("after_rst2_pulse", int'(press_pulse | release_pulse), 0);
    end

    // 256 clean presses wrap the counter back to zero
    step(1'b1, 1'b1, "wrap_rst");
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "wrap_press");
      if (n == 254) check_val("wrap_cnt_255", int'(press_cnt), 255);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, "wrap_release");
    end
    check_val("wrap_cnt",   int'(press_cnt), 0);
    check_val("wrap_vaild", int'(vaild), 0);

    // Randomised key runs with occasional resets, checked every cycle
    for (int s = 0; s < 300; s++) begin
      logic k;
      int   len;
      k   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 49) == 0) step(1'b1, k, "rand_rst");
      for (int i = 0; i < len; i++) step(1'b0, k, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
